// File: rtl/shared_ram_arbiter.sv
// Arbitrates a single-port 16-bit work RAM between the M68K shared-RAM window and the
// byte-wide MCU port; generates M68K DTACK_n and a one-cycle MCU ack.
module shared_ram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              m68k_cs,
  input  logic              m68k_as_n,
  input  logic              m68k_rw,
  input  logic              m68k_uds_n,
  input  logic              m68k_lds_n,
  input  logic [ADDR_W-1:0] m68k_a,
  input  logic [DATA_W-1:0] m68k_din,
  output logic [DATA_W-1:0] m68k_dout,
  output logic              m68k_dtack_n,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W:0]   mcu_addr,
  input  logic [7:0]        mcu_din,
  output logic [7:0]        mcu_dout,
  output logic              mcu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, M_ACC, M_RD, M_HOLD, U_ACC, U_RD} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   ram_addr_nx;
  logic [DATA_W-1:0]   ram_din_nx;
  logic [1:0]          ram_we_nx;
  logic                dtack_n_nx, mcu_ack_nx;
  logic [DATA_W-1:0]   m68k_dout_nx;
  logic [7:0]          mcu_dout_nx;
  logic                mcu_pending, mcu_pending_nx;
  logic                last_mcu, last_mcu_nx;
  logic                m_rd, m_rd_nx;
  logic                m68k_req, mcu_accept, take_mcu;

  // MCU request fields are captured on the accepted pulse since mcu_req is single-cycle
  logic                u_we;
  logic [ADDR_W:0]     u_addr;
  logic [7:0]          u_din;

  always_comb begin
    state_nx       = state;
    ram_addr_nx    = ram_addr;
    ram_din_nx     = ram_din;
    ram_we_nx      = '0;
    dtack_n_nx     = 1'b1;
    mcu_ack_nx     = 1'b0;
    m68k_dout_nx   = m68k_dout;
    mcu_dout_nx    = mcu_dout;
    last_mcu_nx    = last_mcu;
    m_rd_nx        = m_rd;
    take_mcu       = 1'b0;
    m68k_req       = m68k_cs & ~m68k_as_n;
    mcu_accept     = mcu_req & ~mcu_pending & (state != U_ACC) & (state != U_RD);

    case (state)
      IDLE: begin
        // On a tie, last_mcu=1 favours the M68K and last_mcu=0 favours the MCU
        if (m68k_req && (!mcu_pending || last_mcu)) begin
          state_nx    = M_ACC;
          ram_addr_nx = m68k_a;
          last_mcu_nx = 1'b0;
          m_rd_nx     = m68k_rw;
          if (!m68k_rw) begin
            ram_din_nx = m68k_din;
            ram_we_nx  = {~m68k_uds_n, ~m68k_lds_n};
          end
        end else if (mcu_pending) begin
          state_nx    = U_ACC;
          ram_addr_nx = u_addr[ADDR_W:1];
          last_mcu_nx = 1'b1;
          take_mcu    = 1'b1;
          if (u_we) begin
            ram_din_nx = {u_din, u_din};
            ram_we_nx  = u_addr[0] ? 2'b01 : 2'b10;
          end
        end
      end
      M_ACC: begin
        if (m_rd) begin
          state_nx = M_RD;
        end else begin
          state_nx   = M_HOLD;
          dtack_n_nx = m68k_as_n;
        end
      end
      M_RD: begin
        m68k_dout_nx = ram_dout;
        state_nx     = M_HOLD;
        dtack_n_nx   = m68k_as_n;
      end
      M_HOLD: begin
        if (m68k_as_n) state_nx = IDLE;
        else           dtack_n_nx = 1'b0;
      end
      U_ACC: begin
        if (u_we) begin
          mcu_ack_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          state_nx = U_RD;
        end
      end
      U_RD: begin
        mcu_dout_nx = u_addr[0] ? ram_dout[7:0] : ram_dout[15:8];
        mcu_ack_nx  = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (take_mcu)        mcu_pending_nx = 1'b0;
    else if (mcu_accept) mcu_pending_nx = 1'b1;
    else                 mcu_pending_nx = mcu_pending;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_we       <= '0;
      m68k_dtack_n <= 1'b1;
      mcu_ack      <= 1'b0;
      m68k_dout    <= '0;
      mcu_dout     <= '0;
      mcu_pending  <= 1'b0;
      last_mcu     <= 1'b1;
      m_rd         <= 1'b0;
      u_we         <= 1'b0;
      u_addr       <= '0;
      u_din        <= '0;
    end else begin
      state        <= state_nx;
      ram_addr     <= ram_addr_nx;
      ram_din      <= ram_din_nx;
      ram_we       <= ram_we_nx;
      m68k_dtack_n <= dtack_n_nx;
      mcu_ack      <= mcu_ack_nx;
      m68k_dout    <= m68k_dout_nx;
      mcu_dout     <= mcu_dout_nx;
      mcu_pending  <= mcu_pending_nx;
      last_mcu     <= last_mcu_nx;
      m_rd         <= m_rd_nx;
      if (mcu_accept) begin
        u_we   <= mcu_we;
        u_addr <= mcu_addr;
        u_din  <= mcu_din;
      end
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench for shared_ram_arbiter: stimulus pushes expected RAM writes, DTACKs
// and MCU acks; a negedge monitor pops and compares as the DUT presents them.
module tb_shared_ram_arbiter;

  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              m68k_cs = 1'b0, m68k_as_n = 1'b1, m68k_rw = 1'b1;
  logic              m68k_uds_n = 1'b1, m68k_lds_n = 1'b1;
  logic [ADDR_W-1:0] m68k_a = '0;
  logic [15:0]       m68k_din = '0;
  logic [15:0]       m68k_dout;
  logic              m68k_dtack_n;
  logic              mcu_req = 1'b0, mcu_we = 1'b0;
  logic [ADDR_W:0]   mcu_addr = '0;
  logic [7:0]        mcu_din = '0;
  logic [7:0]        mcu_dout;
  logic              mcu_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic [1:0]        ram_we;
  logic [15:0]       ram_dout;
  logic              mem_clr = 1'b1;

  shared_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk_sys(clk), .reset_n(reset_n),
    .m68k_cs(m68k_cs), .m68k_as_n(m68k_as_n), .m68k_rw(m68k_rw),
    .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n), .m68k_a(m68k_a),
    .m68k_din(m68k_din), .m68k_dout(m68k_dout), .m68k_dtack_n(m68k_dtack_n),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
    .mcu_dout(mcu_dout), .mcu_ack(mcu_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM with one-cycle registered read
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
    end else begin
      if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
    end
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        we;
    logic [15:0]       din;
  } wr_t;

  wr_t         wr_q[$];
  logic [16:0] m_q[$];
  logic [8:0]  u_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] we);
    return {{8{we[1]}}, {8{we[0]}}};
  endfunction

  // Monitor
  logic prev_dtack_n = 1'b1, prev_ack = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we != 2'b00) begin
        if (wr_q.size() == 0) begin
          check("unexpected ram_we", {30'b0, ram_we}, 32'h0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("ram_addr", {19'b0, ram_addr}, {19'b0, w.addr});
          check("ram_we", {30'b0, ram_we}, {30'b0, w.we});
          check("ram_din", {16'b0, ram_din & lane_mask(ram_we)}, {16'b0, w.din & lane_mask(w.we)});
        end
      end
      if (!m68k_dtack_n && prev_dtack_n) begin
        if (m_q.size() == 0) begin
          check("unexpected dtack", {31'b0, m68k_dtack_n}, 32'h1);
        end else begin
          logic [16:0] e;
          e = m_q.pop_front();
          if (e[16]) check("m68k_dout", {16'b0, m68k_dout}, {16'b0, e[15:0]});
        end
      end
      if (mcu_ack) begin
        check("mcu_ack single pulse", {31'b0, prev_ack}, 32'h0);
        if (!prev_ack) begin
          if (u_q.size() == 0) begin
            check("unexpected mcu_ack", {31'b0, mcu_ack}, 32'h0);
          end else begin
            logic [8:0] e;
            e = u_q.pop_front();
            if (e[8]) check("mcu_dout", {24'b0, mcu_dout}, {24'b0, e[7:0]});
          end
        end
      end
    end
    prev_dtack_n <= m68k_dtack_n;
    prev_ack     <= mcu_ack;
  end

  // All tasks start and end just after a rising edge unless noted
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mcu_pulse(input logic we, input logic [ADDR_W:0] a, input logic [7:0] d);
    mcu_req = 1'b1; mcu_we = we; mcu_addr = a; mcu_din = d;
    @(posedge clk); #1;
    mcu_req = 1'b0;
  endtask

  task automatic m68k_begin(input logic rw, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                            input logic uds_n, input logic lds_n);
    m68k_cs = 1'b1; m68k_as_n = 1'b0; m68k_rw = rw; m68k_a = a; m68k_din = d;
    m68k_uds_n = uds_n; m68k_lds_n = lds_n;
  endtask

  task automatic m68k_end();
    @(posedge clk); #1;
    m68k_cs = 1'b0; m68k_as_n = 1'b1; m68k_uds_n = 1'b1; m68k_lds_n = 1'b1; m68k_rw = 1'b1;
  endtask

  // Counts rising edges until dtack_n is seen low; returns at a falling edge
  task automatic wait_dtack(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (!m68k_dtack_n) break;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mcu_ack) break;
    end
    @(posedge clk); #1;
  endtask

  int n, lows;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst dtack_n", {31'b0, m68k_dtack_n}, 32'h1);
    check("rst mcu_ack", {31'b0, mcu_ack}, 32'h0);
    check("rst ram_we", {30'b0, ram_we}, 32'h0);
    check("rst ram_addr", {19'b0, ram_addr}, 32'h0);
    check("rst m68k_dout", {16'b0, m68k_dout}, 32'h0);
    check("rst mcu_dout", {24'b0, mcu_dout}, 32'h0);
    mem_clr = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First tie after reset: M68K word write wins, MCU lower-byte write follows AS_n rise
    wr_q.push_back('{addr: 13'h0100, we: 2'b11, din: 16'h1234});
    wr_q.push_back('{addr: 13'h0100, we: 2'b01, din: 16'h00AB});
    m_q.push_back({1'b0, 16'h0});
    u_q.push_back({1'b0, 8'h0});
    mcu_pulse(1'b1, 14'h0201, 8'hAB);
    m68k_begin(1'b0, 13'h0100, 16'h1234, 1'b0, 1'b0);
    wait_dtack(n);
    check("tie1 write latency", n, 2);
    m68k_end();
    wait_ack(n);
    check("mcu grant after AS rise", n, 3);
    idle(2);

    // MCU byte reads of both lanes
    u_q.push_back({1'b1, 8'h12});
    mcu_pulse(1'b0, 14'h0200, 8'h00);
    wait_ack(n);
    u_q.push_back({1'b1, 8'hAB});
    mcu_pulse(1'b0, 14'h0201, 8'h00);
    wait_ack(n);
    idle(2);

    // M68K word read
    m_q.push_back({1'b1, 16'h12AB});
    m68k_begin(1'b1, 13'h0100, 16'h0, 1'b0, 1'b0);
    wait_dtack(n);
    check("read latency", n, 3);
    m68k_end();
    idle(2);

    // Tie with last grant = M68K: MCU read first, then LDS-only M68K write
    u_q.push_back({1'b1, 8'h12});
    wr_q.push_back('{addr: 13'h0100, we: 2'b01, din: 16'h00EE});
    m_q.push_back({1'b0, 16'h0});
    mcu_pulse(1'b0, 14'h0200, 8'h00);
    m68k_begin(1'b0, 13'h0100, 16'hFFEE, 1'b1, 1'b0);
    wait_dtack(n);
    check("tie2 M68K waits for MCU", n, 5);
    m68k_end();
    idle(2);

    m_q.push_back({1'b1, 16'h12EE});
    m68k_begin(1'b1, 13'h0100, 16'h0, 1'b0, 1'b0);
    wait_dtack(n);
    check("read latency 2", n, 3);
    m68k_end();
    idle(2);

    // M68K write with no strobes; two MCU pulses, the second while pending
    m_q.push_back({1'b0, 16'h0});
    wr_q.push_back('{addr: 13'h0180, we: 2'b10, din: 16'h5500});
    u_q.push_back({1'b0, 8'h0});
    m68k_begin(1'b0, 13'h0180, 16'hBEEF, 1'b1, 1'b1);
    fork
      begin
        wait_dtack(n);
        check("no-strobe write dtack", n, 2);
        m68k_end();
      end
      begin
        mcu_pulse(1'b1, 14'h0300, 8'h55);
        @(posedge clk); #1;
        mcu_pulse(1'b1, 14'h0301, 8'h66);
      end
    join
    wait_ack(n);
    idle(4);
    m_q.push_back({1'b1, 16'h5500});
    m68k_begin(1'b1, 13'h0180, 16'h0, 1'b0, 1'b0);
    wait_dtack(n);
    m68k_end();
    idle(2);

    // AS_n rises after grant: RAM written, no dtack
    wr_q.push_back('{addr: 13'h1FFF, we: 2'b11, din: 16'hA5A5});
    m68k_begin(1'b0, 13'h1FFF, 16'hA5A5, 1'b0, 1'b0);
    @(posedge clk); #1;
    m68k_cs = 1'b0; m68k_as_n = 1'b1;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (!m68k_dtack_n) lows++;
    end
    check("no dtack after late AS rise", lows, 0);
    idle(1);

    // AS_n rises before grant (MCU busy): no RAM access, no dtack
    u_q.push_back({1'b1, 8'h55});
    mcu_pulse(1'b0, 14'h0300, 8'h00);
    @(posedge clk); #1;
    m68k_begin(1'b0, 13'h0010, 16'hDEAD, 1'b0, 1'b0);
    @(posedge clk); #1;
    m68k_cs = 1'b0; m68k_as_n = 1'b1;
    wait_ack(n);
    lows = 0;
    repeat (4) begin
      @(negedge clk);
      if (!m68k_dtack_n) lows++;
    end
    check("no dtack after early AS rise", lows, 0);
    idle(1);

    // Reset in M_HOLD with an MCU write pending
    wr_q.push_back('{addr: 13'h0020, we: 2'b11, din: 16'h1111});
    m_q.push_back({1'b0, 16'h0});
    m68k_begin(1'b0, 13'h0020, 16'h1111, 1'b0, 1'b0);
    mcu_pulse(1'b1, 14'h0040, 8'h77);
    wait_dtack(n);
    check("dtack before reset", {31'b0, m68k_dtack_n}, 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("hold rst dtack_n", {31'b0, m68k_dtack_n}, 32'h1);
    check("hold rst ram_we", {30'b0, ram_we}, 32'h0);
    check("hold rst mcu_ack", {31'b0, mcu_ack}, 32'h0);
    m68k_cs = 1'b0; m68k_as_n = 1'b1; m68k_uds_n = 1'b1; m68k_lds_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(6);

    // Reset in U_RD
    mcu_pulse(1'b0, 14'h0200, 8'h00);
    idle(1);
    idle(1);
    reset_n = 1'b0;
    #1;
    check("urd rst mcu_ack", {31'b0, mcu_ack}, 32'h0);
    check("urd rst ram_we", {30'b0, ram_we}, 32'h0);
    check("urd rst dtack_n", {31'b0, m68k_dtack_n}, 32'h1);
    check("urd rst mcu_dout", {24'b0, mcu_dout}, 32'h0);
    check("urd rst m68k_dout", {16'b0, m68k_dout}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(6);

    // Normal operation after reset
    m_q.push_back({1'b1, 16'h1111});
    m68k_begin(1'b1, 13'h0020, 16'h0, 1'b0, 1'b0);
    wait_dtack(n);
    check("post-reset read latency", n, 3);
    m68k_end();
    idle(2);
    u_q.push_back({1'b1, 8'h11});
    mcu_pulse(1'b0, 14'h0041, 8'h00);
    wait_ack(n);
    idle(5);

    check("wr_q drained", wr_q.size(), 0);
    check("m_q drained", m_q.size(), 0);
    check("u_q drained", u_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Arbitrates one single-port 16-bit work RAM between the M68K (shared-RAM chip select region) and the sprite/protection MCU (byte-wide port), as required by the bigfghtr-class PCB.
- Generates M68K DTACK_n for the shared region and a one-cycle ack for the MCU.
- Sits between the chip-select decode and the BRAM instance. The RAM has 1-cycle registered read latency.

Parameters:
- ADDR_W, 13, RAM word-address width (8K words)
- DATA_W, 16, RAM word width (fixed 16; MCU uses byte lanes)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m68k_cs  in  1  shared-RAM chip select from decode (already qualified with AS_n)
- m68k_as_n  in  1  M68K address strobe
- m68k_rw  in  1  1=read, 0=write
- m68k_uds_n  in  1  upper data strobe
- m68k_lds_n  in  1  lower data strobe
- m68k_a  in  ADDR_W  word address (A[ADDR_W:1])
- m68k_din  in  16  write data from M68K
- m68k_dout  out  16  read data to M68K, held until next M68K read
- m68k_dtack_n  out  1  data acknowledge for shared region
- mcu_req  in  1  single-cycle access request pulse
- mcu_we  in  1  1=write byte
- mcu_addr  in  ADDR_W+1  byte address; bit0=0 selects upper byte (big-endian)
- mcu_din  in  8  write byte
- mcu_dout  out  8  read byte, held until next MCU read
- mcu_ack  out  1  one-cycle completion pulse
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  16  RAM write data
- ram_we  out  2  byte write enables {upper, lower}
- ram_dout  in  16  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Reset (async, any state) forces:
  - state IDLE; m68k_dtack_n=1; mcu_ack=0; ram_we=0; ram_addr=0
  - m68k_dout=0; mcu_dout=0; mcu_pending=0; last_grant=MCU
- Requests:
  - m68k_req = m68k_cs & !m68k_as_n, sampled in IDLE.
  - mcu_req pulse sets mcu_pending; pending clears when the MCU grant is taken.
  - A mcu_req arriving while pending or in an MCU access is ignored (protocol violation; no queueing).
- Arbitration in IDLE:
  - If only one requester, grant it.
  - If both, grant the one not equal to last_grant, so the first tie after reset goes to the M68K.
  - last_grant updates on every grant.
- States: IDLE, M_ACC, M_RD, M_HOLD, U_ACC, U_RD.
- M_ACC (1 cycle):
  - ram_addr=m68k_a.
  - Write: ram_din=m68k_din, ram_we={!uds_n,!lds_n}.
  - Read: ram_we=0.
  - Write goes to M_HOLD; read goes to M_RD.
- M_RD: latch m68k_dout<=ram_dout, then M_HOLD.
- M_HOLD:
  - m68k_dtack_n=0 while m68k_as_n=0.
  - When m68k_as_n=1: dtack_n=1 in the same registered update, then IDLE.
  - The M68K cannot re-request until AS_n has risen.
- Latency, grant cycle to dtack_n low: write 1 clock, read 2 clocks (registered outputs).
- U_ACC (1 cycle):
  - ram_addr=mcu_addr[ADDR_W:1].
  - Write: ram_din={mcu_din,mcu_din}; ram_we=2'b10 if mcu_addr[0]=0, else 2'b01; mcu_ack pulse next cycle, then IDLE.
  - Read: go to U_RD.
- U_RD: mcu_dout <= mcu_addr[0] ? ram_dout[7:0] : ram_dout[15:8]; mcu_ack=1 for one cycle; then IDLE.
- ram_we is non-zero only in the write cycle of M_ACC/U_ACC; it is never asserted in IDLE or HOLD.
- AS_n rises before grant: request dropped, no RAM access.
- AS_n rises after grant: access completes to RAM, dtack is not asserted, return to IDLE.
- Byte writes with both strobes high (uds_n=lds_n=1) on a write: ram_we=0, dtack still returned.
- Back-to-back throughput: a waiting MCU request is granted in the first IDLE cycle after M_HOLD exits, before any new M68K cycle (round-robin).

Test Plan:
- M68K word write 0x1234 to word 0x0100 with UDS/LDS low, then read back → ram_we=2'b11 one cycle; read dtack_n low 2 clocks after grant; m68k_dout=0x1234.
- MCU byte write 0xAB to byte addr 0x0201 (word 0x0100, lower), then MCU read of 0x0200 and 0x0201 → ram_we=2'b01; reads return 0x12 and 0xAB; mcu_ack single-cycle pulse each.
- Simultaneous M68K and MCU request first cycle after reset → M68K granted first. MCU granted immediately after AS_n rises. Next tie → MCU first.
- M68K write with only LDS low, data 0xFFEE to word 0x0100 → word reads 0x12EE.
- reset_n asserted during M_HOLD and during U_RD → dtack_n=1, mcu_ack=0, ram_we=0 immediately; after release, new accesses behave normally; mcu_pending cleared.
- Second mcu_req pulse while the first is pending behind an M68K cycle → only one MCU access performed; exactly one mcu_ack.
